// File: rtl/decoder_scan_pkg.sv
// Shared encodings for the 74LS138 scan driver.
//   mode_e  : scan mode as presented on the mode input
//   state_e : scan FSM states
//   ENA_ON / ENA_OFF : {G, G2A, G2B} patterns for an enabled / disabled decoder
//   sel_wrap: one step of the select code with wrap between last and 0
package decoder_scan_pkg;

    typedef enum logic [1:0] {
        MODE_UP    = 2'b00,
        MODE_DN    = 2'b01,
        MODE_SWEEP = 2'b10,
        MODE_HOLD  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BLANK  = 2'd2
    } state_e;

    // {G, G2A, G2B}: G is active-high, G2A/G2B are active-low.
    localparam logic [2:0] ENA_ON  = 3'b100;
    localparam logic [2:0] ENA_OFF = 3'b011;

    function automatic logic [2:0] sel_wrap(input logic [2:0] sel, input logic up,
                                            input logic [2:0] last);
        if (up) begin
            return (sel == last) ? 3'd0 : sel + 3'd1;
        end
        return (sel == 3'd0) ? last : sel - 3'd1;
    endfunction

endpackage

// File: rtl/scan_dwell_counter.sv
// Dwell counter for the scan FSM.
//   clk   : system clock
//   rst   : synchronous active-high reset, counter to 0
//   clr   : load 0 on the next edge (wins over hold)
//   hold  : freeze the count
//   limit : terminal count value for the current dwell
//   tc    : high while the count equals limit
module scan_dwell_counter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             hold,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (!hold) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tc = (cnt_q == limit);

endmodule

// File: rtl/decoder_scan_driver.sv
// Scan driver for a 74LS138 3-to-8 decoder. Steps the select code through channels with an
// ACTIVE dwell per channel and a BLANK gap (decoder disabled) between channels.
//   clk, rst         : clock, synchronous active-high reset
//   en               : run enable, low forces IDLE
//   mode             : 00 up, 01 down, 10 single sweep, 11 hold
//   start            : starts a sweep in mode 10 when idle
//   C, B, A          : registered select code, C is MSB
//   G, G2A, G2B      : registered decoder enables, asserted only in ACTIVE
//   busy             : high whenever not IDLE
//   done             : one-cycle pulse in the first IDLE cycle after a sweep
module decoder_scan_driver
    import decoder_scan_pkg::*;
#(
    parameter int unsigned TICK_DIV     = 50000,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned LAST_CH      = 7,
    parameter int unsigned CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [1:0] mode,
    input  logic       start,
    output logic       C,
    output logic       B,
    output logic       A,
    output logic       G,
    output logic       G2A,
    output logic       G2B,
    output logic       busy,
    output logic       done
);

    localparam logic [CNT_W-1:0] ACT_LIM   = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLK_LIM   = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [2:0]       LAST      = 3'(LAST_CH);
    localparam bit               HAS_BLANK = (BLANK_CYCLES > 0);

    state_e           state_q, state_d;
    mode_e            mode_q, mode_d;
    logic [2:0]       sel_q, sel_d;
    logic [2:0]       ena_q, ena_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             tc, clr, hold, wrap;
    logic [CNT_W-1:0] limit;

    // After a channel's dwell: BLANK if blanking is configured, otherwise straight to ACTIVE.
    localparam state_e ST_AFTER = HAS_BLANK ? ST_BLANK : ST_ACTIVE;

    scan_dwell_counter #(
        .CNT_W (CNT_W)
    ) u_dwell (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .hold  (hold),
        .limit (limit),
        .tc    (tc)
    );

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= MODE_UP;
            sel_q   <= 3'd0;
            ena_q   <= ENA_OFF;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sel_q   <= sel_d;
            ena_q   <= ena_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Next state, select code and counter control.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sel_d   = sel_q;
        done_d  = 1'b0;
        wrap    = 1'b0;
        limit   = (state_q == ST_BLANK) ? BLK_LIM : ACT_LIM;
        hold    = (state_q == ST_IDLE) || (state_q == ST_ACTIVE && mode_q == MODE_HOLD);

        if (!en) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (mode_e'(mode) != MODE_SWEEP || start) begin
                        state_d = ST_ACTIVE;
                        mode_d  = mode_e'(mode);
                        if (mode_e'(mode) == MODE_SWEEP) begin
                            sel_d = 3'd0;
                        end
                    end
                end
                ST_ACTIVE: begin
                    if (tc && mode_q != MODE_HOLD) begin
                        wrap = 1'b1;
                        unique case (mode_q)
                            MODE_UP: begin
                                sel_d   = sel_wrap(sel_q, 1'b1, LAST);
                                state_d = ST_AFTER;
                            end
                            MODE_DN: begin
                                sel_d   = sel_wrap(sel_q, 1'b0, LAST);
                                state_d = ST_AFTER;
                            end
                            MODE_SWEEP: begin
                                if (sel_q == LAST) begin
                                    state_d = ST_IDLE;
                                    done_d  = 1'b1;
                                end else begin
                                    sel_d   = sel_q + 3'd1;
                                    state_d = ST_AFTER;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_BLANK: begin
                    if (tc) begin
                        state_d = ST_ACTIVE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        // Restart the dwell on any state change, and on ACTIVE->ACTIVE when blanking is off.
        clr = (state_d != state_q) || wrap;
    end

    // Registered outputs follow the next state so they line up with the state they describe.
    always_comb begin
        ena_d  = (state_d == ST_ACTIVE) ? ENA_ON : ENA_OFF;
        busy_d = (state_d != ST_IDLE);
    end

    assign {C, B, A}     = sel_q;
    assign {G, G2A, G2B} = ena_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: tb/tb_decoder_scan_driver.sv
module tb_decoder_scan_driver;

    localparam int TD = 4;
    localparam int BC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance: TICK_DIV=4, BLANK_CYCLES=2, LAST_CH=7
    logic       rst = 1'b1, en = 1'b0, start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       C, B, A, G, G2A, G2B, busy, done;
    logic [7:0] obs;
    assign obs = {C, B, A, G, G2A, G2B, busy, done};

    // Second instance: LAST_CH=3, no blanking
    logic       rst2 = 1'b1, en2 = 1'b0, start2 = 1'b0;
    logic [1:0] mode2 = 2'b00;
    logic       C2, B2, A2, G_2, G2A_2, G2B_2, busy2, done2;
    logic [7:0] obs2;
    assign obs2 = {C2, B2, A2, G_2, G2A_2, G2B_2, busy2, done2};

    decoder_scan_driver #(
        .TICK_DIV (4), .BLANK_CYCLES (2), .LAST_CH (7), .CNT_W (16)
    ) dut (
        .clk (clk), .rst (rst), .en (en), .mode (mode), .start (start),
        .C (C), .B (B), .A (A), .G (G), .G2A (G2A), .G2B (G2B), .busy (busy), .done (done)
    );

    decoder_scan_driver #(
        .TICK_DIV (4), .BLANK_CYCLES (0), .LAST_CH (3), .CNT_W (16)
    ) dut2 (
        .clk (clk), .rst (rst2), .en (en2), .mode (mode2), .start (start2),
        .C (C2), .B (B2), .A (A2), .G (G_2), .G2A (G2A_2), .G2B (G2B_2),
        .busy (busy2), .done (done2)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    int t_entry = 0;

    // Expected {sel, G, G2A, G2B, busy, done}
    function automatic logic [7:0] f_act(input int s);
        return {3'(s), 5'b10010};
    endfunction
    function automatic logic [7:0] f_blk(input int s);
        return {3'(s), 5'b01110};
    endfunction
    function automatic logic [7:0] f_idle(input int s);
        return {3'(s), 5'b01100};
    endfunction
    function automatic logic [7:0] f_done(input int s);
        return {3'(s), 5'b01101};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b want %b (sel,G,G2A,G2B,busy,done) cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Enter a free-run scan from IDLE and check nch full channels (dwell + blank).
    task automatic run_free(input logic [1:0] m, input int first, input int nch,
                            input string nm);
        int s, nx;
        s = first;
        en = 1'b1; mode = m; start = 1'b0;
        for (int c = 0; c < nch; c++) begin
            nx = (m == 2'b00) ? ((s == 7) ? 0 : s + 1) : ((s == 0) ? 7 : s - 1);
            for (int i = 0; i < TD; i++) begin
                tick();
                if (c == 0 && i == 0) t_entry = cyc;
                chk(nm, obs, f_act(s));
            end
            for (int i = 0; i < BC; i++) begin
                tick();
                chk(nm, obs, f_blk(nx));
            end
            s = nx;
        end
    endtask

    // The select code must never change between two consecutive enabled samples.
    logic       mon_g = 1'b0;
    logic [2:0] mon_sel = 3'd0;
    always @(negedge clk) begin
        if (mon_g && G === 1'b1) begin
            checks++;
            if ({C, B, A} !== mon_sel) begin
                errors++;
                $display("FAIL sel_stable: got %b want %b while G=1 cycle %0d",
                         {C, B, A}, mon_sel, cyc);
            end
        end
        mon_g   = (G === 1'b1);
        mon_sel = {C, B, A};
    end

    typedef struct {
        logic       r;
        logic       e;
        logic [1:0] m;
        logic       s;
        logic [7:0] x;
    } vec_t;
    vec_t tbl[$];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cnt, early;

        // Reset, release, first two channels of an up scan, then reset/enable corners.
        for (int i = 0; i < 3; i++) tbl.push_back('{1'b1, 1'b1, 2'b00, 1'b0, f_idle(0)});
        for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, 1'b1, 2'b00, 1'b0, f_act(0)});
        for (int i = 0; i < 2; i++) tbl.push_back('{1'b0, 1'b1, 2'b00, 1'b0, f_blk(1)});
        for (int i = 0; i < 4; i++) tbl.push_back('{1'b0, 1'b1, 2'b00, 1'b0, f_act(1)});
        tbl.push_back('{1'b0, 1'b1, 2'b00, 1'b0, f_blk(2)});
        tbl.push_back('{1'b1, 1'b1, 2'b00, 1'b0, f_idle(0)});  // rst mid-BLANK
        tbl.push_back('{1'b1, 1'b1, 2'b10, 1'b1, f_idle(0)});  // rst beats start
        tbl.push_back('{1'b0, 1'b0, 2'b00, 1'b0, f_idle(0)});  // en low stays idle
        tbl.push_back('{1'b0, 1'b0, 2'b10, 1'b1, f_idle(0)});  // start with en low
        tbl.push_back('{1'b0, 1'b1, 2'b10, 1'b0, f_idle(0)});  // sweep waits for start

        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; en = tbl[i].e; mode = tbl[i].m; start = tbl[i].s;
            tick();
            chk($sformatf("vec%0d", i), obs, tbl[i].x);
        end
        start = 1'b0;

        // Full up scan and its period.
        run_free(2'b00, 0, 8, "up_scan");
        for (int k = 0; k < 20 && obs[4] !== 1'b1; k++) tick();
        chk_int("up_period", cyc - t_entry, 48);
        chk("up_wrap0", obs, f_act(0));
        en = 1'b0;
        tick();
        chk("en_drop_idle", obs, f_idle(0));

        // Down scan wraps 0 -> 7 first.
        run_free(2'b01, 0, 3, "down_scan");
        rst = 1'b1;
        tick();
        chk("rst_mid_blank", obs, f_idle(0));
        rst = 1'b0;

        // en dropped mid-dwell at sel 3, then resumed with a full dwell.
        run_free(2'b00, 0, 3, "up_to3");
        tick(); chk("at3_a", obs, f_act(3));
        tick(); chk("at3_b", obs, f_act(3));
        en = 1'b0;
        tick(); chk("drop3_a", obs, f_idle(3));
        tick(); chk("drop3_b", obs, f_idle(3));
        run_free(2'b00, 3, 1, "resume3");
        en = 1'b0;
        tick(); chk("idle4", obs, f_idle(4));

        // Single sweep from a held sel of 4; a second start mid-sweep is ignored.
        en = 1'b1; mode = 2'b10; start = 1'b1;
        tick(); chk("sweep_start", obs, f_act(0));
        start = 1'b0;
        busy_cnt = 1; early = 0;
        for (int k = 0; k < 100; k++) begin
            start = (k == 10);
            tick();
            if (obs[1] !== 1'b1) break;
            busy_cnt++;
            if (obs[0] !== 1'b0) early++;
        end
        start = 1'b0;
        chk_int("sweep_busy_len", busy_cnt, 46);
        chk_int("sweep_early_done", early, 0);
        chk("sweep_done", obs, f_done(7));
        tick(); chk("sweep_after", obs, f_idle(7));
        en = 1'b0;

        // LAST_CH=3, no blanking: continuous enable, 4 cycles per sel; rst mid-dwell.
        tick(); chk("ls3_reset", obs2, f_idle(0));
        rst2 = 1'b0; en2 = 1'b1; mode2 = 2'b00;
        for (int c = 0; c < 5; c++) begin
            for (int i = 0; i < TD; i++) begin
                tick();
                chk($sformatf("ls3_ch%0d", c), obs2, f_act(c % 4));
            end
        end
        tick(); chk("ls3_mid_a", obs2, f_act(1));
        tick(); chk("ls3_mid_b", obs2, f_act(1));
        rst2 = 1'b1;
        tick(); chk("ls3_rst", obs2, f_idle(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
